// File: rtl/simple_hazard_ctrl.sv
// simple_hazard_ctrl: register-interlock scoreboard with pipeline drain.
// Optional stall counter enabled by SIMPLE_HAZARD_STALLCNT_EN.
module simple_hazard_ctrl #(
   parameter int CNT_W = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        dec_valid,
   input  logic [15:0] dec_command,
   input  logic        wb_valid,
   input  logic [2:0]  wb_target,
   input  logic        drain_req,
   output logic        stall,
   output logic        issue,
   output logic        drain_done,
   output logic        sb_busy,
   output logic        err_underflow
`ifdef SIMPLE_HAZARD_STALLCNT_EN
   ,
   output logic [15:0] stall_cycles
`endif
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

   state_t           state;
   logic [CNT_W-1:0] cnt     [8];
   logic [CNT_W-1:0] cnt_nxt [8];

   logic [1:0] cls;
   logic [2:0] rs1;
   logic [2:0] rs2;
   logic [2:0] dest;
   logic       has_src;
   logic       has_dest;
   logic       hazard;
   logic       uf;
   logic       nxt_zero;
   logic       unused;

   // bit 3 of the command carries nothing the interlock needs
   assign unused = dec_command[3];

   // field extraction per instruction class
   always_comb begin
      cls      = dec_command[15:14];
      rs1      = dec_command[13:11];
      rs2      = dec_command[10:8];
      dest     = dec_command[10:8];
      has_src  = 1'b1;
      has_dest = 1'b1;
      unique case (cls)
         2'd3: begin
            if (dec_command[7:4] > 4'd8)
               rs2 = dec_command[2:0];
         end
         2'd0: dest = dec_command[13:11];
         2'd1: has_dest = 1'b0;
         2'd2: has_src = 1'b0;
         default: ;
      endcase
   end

   // interlock: pending source write or saturated destination
   always_comb begin
      hazard = dec_valid &&
               ((has_src && (cnt[rs1] != '0)) ||
                (has_src && (cnt[rs2] != '0)) ||
                (has_dest && (cnt[dest] == CMAX)));
      stall  = hazard || (state != RUN);
      issue  = dec_valid && !stall;
   end

   // next counter values; issue and writeback on one register cancel
   always_comb begin
      uf       = 1'b0;
      nxt_zero = 1'b1;
      for (int r = 0; r < 8; r++) begin
         cnt_nxt[r] = cnt[r];
         if (issue && has_dest && (dest == 3'(r))) begin
            if (!(wb_valid && (wb_target == 3'(r))))
               cnt_nxt[r] = cnt[r] + CNT_W'(1);
         end else if (wb_valid && (wb_target == 3'(r))) begin
            if (cnt[r] == '0)
               uf = 1'b1;
            else
               cnt_nxt[r] = cnt[r] - CNT_W'(1);
         end
         if (cnt_nxt[r] != '0)
            nxt_zero = 1'b0;
      end
   end

   // busy flag decoded from registered counters only
   always_comb begin
      sb_busy = 1'b0;
      for (int r = 0; r < 8; r++)
         sb_busy = sb_busy | (cnt[r] != '0);
   end

   // scoreboard counters and sticky underflow flag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < 8; r++)
            cnt[r] <= '0;
         err_underflow <= 1'b0;
      end else begin
         for (int r = 0; r < 8; r++)
            cnt[r] <= cnt_nxt[r];
         if (uf)
            err_underflow <= 1'b1;
      end
   end

   // drain sequencer with registered completion pulse
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= RUN;
         drain_done <= 1'b0;
      end else begin
         drain_done <= 1'b0;
         unique case (state)
            RUN: begin
               if (drain_req)
                  state <= DRAIN;
            end
            DRAIN: begin
               if (nxt_zero) begin
                  state      <= DONE;
                  drain_done <= 1'b1;
               end
            end
            DONE: state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

`ifdef SIMPLE_HAZARD_STALLCNT_EN
   // saturating count of cycles a valid decode was held
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         stall_cycles <= '0;
      else if (dec_valid && stall && (stall_cycles != 16'hFFFF))
         stall_cycles <= stall_cycles + 16'd1;
   end
`endif

endmodule
